// File: rtl/alu_rdig_pkg.sv
// Shared definitions for the RLD/RRD nibble-rotate unit (alu_rdig).
// Holds the FSM state encodings, the operation encodings and the flag layout.
package alu_rdig_pkg;

  // Sequencer states: one memory read, one execute, one memory write, then done.
  typedef enum logic [2:0] {
    RDIG_IDLE  = 3'd0,
    RDIG_READ  = 3'd1,
    RDIG_EXEC  = 3'd2,
    RDIG_WRITE = 3'd3,
    RDIG_DONE  = 3'd4
  } rdig_state_t;

  // Operation select values carried on rdig_op.
  localparam logic RDIG_RLD = 1'b0;
  localparam logic RDIG_RRD = 1'b1;

  // Flag bundle in the order driven on flag_out: {S, Z, P, H}.
  typedef struct packed {
    logic s;
    logic z;
    logic p;
    logic h;
  } rdig_flags_t;

  // Even parity: 1 when the byte holds an even number of ones.
  function automatic logic even_parity(input logic [7:0] value);
    return ~(^value);
  endfunction

endpackage

// File: rtl/alu_rdig_calc.sv
// rdig_calc: purely combinational data path for RLD/RRD.
// Rotates nibbles between the accumulator and the memory byte and derives
// S/Z/P/H from the new accumulator value.
module rdig_calc
  import alu_rdig_pkg::*;
(
  input  logic       op,
  input  logic [7:0] a,
  input  logic [7:0] mem,
  output logic [7:0] new_mem,
  output logic [7:0] new_a,
  output logic [3:0] flags
);

  rdig_flags_t flags_s;

  // Nibble rotation for the selected direction; the accumulator high nibble is always preserved.
  always_comb begin
    new_mem = 8'h00;
    new_a   = 8'h00;
    case (op)
      RDIG_RLD: begin
        new_mem = {mem[3:0], a[3:0]};
        new_a   = {a[7:4], mem[7:4]};
      end
      RDIG_RRD: begin
        new_mem = {a[3:0], mem[7:4]};
        new_a   = {a[7:4], mem[3:0]};
      end
      default: begin
        new_mem = 8'h00;
        new_a   = 8'h00;
      end
    endcase
  end

  // Flags come from the rotated accumulator; half-carry is always cleared.
  always_comb begin
    flags_s   = '0;
    flags_s.s = new_a[7];
    flags_s.z = (new_a == 8'h00);
    flags_s.p = even_parity(new_a);
    flags_s.h = 1'b0;
    flags          = flags_s;
  end

endmodule

// File: rtl/alu_rdig.sv
// alu_rdig: sequencer for the RLD/RRD instructions.
// Reads the byte at HL, rotates nibbles with the accumulator (rdig_calc),
// writes the byte back and presents the new accumulator plus {S,Z,P,H}.
// Build option: define RDIG_WAIT_EN to let mem_ack stretch READ and WRITE;
// without it every memory phase lasts exactly one cycle and mem_ack is ignored.
module alu_rdig
  import alu_rdig_pkg::*;
(
  input  logic        clkc,
  input  logic        resetb,
  input  logic        rdig_start,
  input  logic        rdig_op,
  input  logic [15:0] addr_in,
  input  logic [7:0]  a_in,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  a_out,
  output logic [3:0]  flag_out,
  output logic        busy,
  output logic        done
);

  rdig_state_t state_r;
  rdig_state_t next_state_s;

  logic        op_r;
  logic [7:0]  a_r;
  logic [15:0] addr_r;
  logic [7:0]  mem_r;
  logic [7:0]  new_mem_r;
  logic [7:0]  new_a_r;
  logic [3:0]  flags_r;

  logic [7:0]  calc_mem_s;
  logic [7:0]  calc_a_s;
  logic [3:0]  calc_flags_s;
  logic        mem_ready_s;
  logic        accept_s;
  logic [15:0] addr_sel_s;
  logic [7:0]  wdata_sel_s;

`ifdef RDIG_WAIT_EN
  assign mem_ready_s = mem_ack;
`else
  // Fixed single-cycle memory phases: the acknowledge is intentionally not consulted.
  logic unused_mem_ack;
  assign unused_mem_ack = mem_ack;
  assign mem_ready_s    = 1'b1;
`endif

  assign accept_s = (state_r == RDIG_IDLE) && rdig_start;

  rdig_calc u_calc (
    .op      (op_r),
    .a       (a_r),
    .mem     (mem_r),
    .new_mem (calc_mem_s),
    .new_a   (calc_a_s),
    .flags   (calc_flags_s)
  );

  // Next-state logic: a start is only honoured in IDLE, so requests while busy are dropped.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RDIG_IDLE: begin
        if (rdig_start) next_state_s = RDIG_READ;
        else            next_state_s = RDIG_IDLE;
      end
      RDIG_READ: begin
        if (mem_ready_s) next_state_s = RDIG_EXEC;
        else             next_state_s = RDIG_READ;
      end
      RDIG_EXEC:  next_state_s = RDIG_WRITE;
      RDIG_WRITE: begin
        if (mem_ready_s) next_state_s = RDIG_DONE;
        else             next_state_s = RDIG_WRITE;
      end
      RDIG_DONE:  next_state_s = RDIG_IDLE;
      default:    next_state_s = RDIG_IDLE;
    endcase
  end

  // Address and write data for the registered bus outputs; the IDLE path forwards addr_in
  // so the strobe cycle already carries the address being latched.
  always_comb begin
    addr_sel_s  = addr_r;
    wdata_sel_s = new_mem_r;
    if (state_r == RDIG_IDLE) addr_sel_s = addr_in;
    else                      addr_sel_s = addr_r;
    if (state_r == RDIG_EXEC) wdata_sel_s = calc_mem_s;
    else                      wdata_sel_s = new_mem_r;
  end

  // State, operand latches, intermediate results and registered outputs.
  always_ff @(posedge clkc) begin
    if (!resetb) begin
      state_r   <= RDIG_IDLE;
      op_r      <= RDIG_RLD;
      a_r       <= 8'h00;
      addr_r    <= 16'h0000;
      mem_r     <= 8'h00;
      new_mem_r <= 8'h00;
      new_a_r   <= 8'h00;
      flags_r   <= 4'h0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      a_out     <= 8'h00;
      flag_out  <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r <= next_state_s;

      if (accept_s) begin
        op_r   <= rdig_op;
        a_r    <= a_in;
        addr_r <= addr_in;
      end

      if ((state_r == RDIG_READ) && mem_ready_s) begin
        mem_r <= mem_rdata;
      end

      if (state_r == RDIG_EXEC) begin
        new_mem_r <= calc_mem_s;
        new_a_r   <= calc_a_s;
        flags_r   <= calc_flags_s;
      end

      if ((state_r == RDIG_WRITE) && (next_state_s == RDIG_DONE)) begin
        a_out    <= new_a_r;
        flag_out <= flags_r;
      end

      mem_rd    <= (next_state_s == RDIG_READ);
      mem_wr    <= (next_state_s == RDIG_WRITE);
      mem_addr  <= ((next_state_s == RDIG_READ) || (next_state_s == RDIG_WRITE)) ? addr_sel_s : 16'h0000;
      mem_wdata <= (next_state_s == RDIG_WRITE) ? wdata_sel_s : 8'h00;
      busy      <= (next_state_s != RDIG_IDLE);
      done      <= (next_state_s == RDIG_DONE);
    end
  end

endmodule

// File: tb/tb_alu_rdig.sv
// Self-checking bench for alu_rdig: directed RLD/RRD cases, randomized
// operations against a nibble-arithmetic reference model, start-while-busy
// and mid-operation reset.
module tb_alu_rdig;

  logic        clkc = 1'b0;
  logic        resetb = 1'b0;
  logic        rdig_start = 1'b0;
  logic        rdig_op = 1'b0;
  logic [15:0] addr_in = 16'h0000;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b1;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  a_out;
  logic [3:0]  flag_out;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  alu_rdig dut (
    .clkc       (clkc),
    .resetb     (resetb),
    .rdig_start (rdig_start),
    .rdig_op    (rdig_op),
    .addr_in    (addr_in),
    .a_in       (a_in),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .a_out      (a_out),
    .flag_out   (flag_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clkc = ~clkc;

  task automatic tick();
    @(posedge clkc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: RLD moves mem low nibble up and A low nibble into mem;
  // RRD moves A low nibble to mem high and mem high nibble down.
  function automatic logic [7:0] model_mem(input logic op, input logic [7:0] a, input logic [7:0] m);
    int r;
    if (op) r = (int'(a % 16) * 16) + int'(m / 16);
    else    r = (int'(m % 16) * 16) + int'(a % 16);
    return r[7:0];
  endfunction

  function automatic logic [7:0] model_a(input logic op, input logic [7:0] a, input logic [7:0] m);
    int r;
    if (op) r = (int'(a / 16) * 16) + int'(m % 16);
    else    r = (int'(a / 16) * 16) + int'(m / 16);
    return r[7:0];
  endfunction

  function automatic logic [3:0] model_flags(input logic [7:0] na);
    logic s, z, p;
    s = (na >= 8'd128);
    z = (na == 8'd0);
    p = (($countones(na) % 2) == 0);
    return {s, z, p, 1'b0};
  endfunction

  // One full zero-wait operation, checked cycle by cycle (start at cycle 0, DONE at cycle 4).
  task automatic do_op(input string tag, input logic op, input logic [7:0] a, input logic [7:0] m,
                       input logic [15:0] addr, input logic ack, input logic poke_in_write);
    logic [7:0] exp_mem, exp_a;
    logic [3:0] exp_f;
    exp_mem = model_mem(op, a, m);
    exp_a   = model_a(op, a, m);
    exp_f   = model_flags(exp_a);
    rdig_start = 1'b1; rdig_op = op; a_in = a; addr_in = addr; mem_ack = ack;
    tick();
    // cycle 1: READ; disturb the operand inputs, they must already be latched
    rdig_start = 1'b0; a_in = 8'($urandom); addr_in = 16'($urandom); rdig_op = ~op;
    chk({tag, " rd"}, {15'd0, mem_rd}, 16'd1);
    chk({tag, " rd_nowr"}, {15'd0, mem_wr}, 16'd0);
    chk({tag, " rd_addr"}, mem_addr, addr);
    chk({tag, " rd_busy"}, {15'd0, busy}, 16'd1);
    mem_rdata = m;
    tick();
    // cycle 2: EXEC
    mem_rdata = 8'($urandom);
    chk({tag, " ex_strobes"}, {14'd0, mem_rd, mem_wr}, 16'd0);
    chk({tag, " ex_addr"}, mem_addr, 16'h0000);
    tick();
    // cycle 3: WRITE
    chk({tag, " wr"}, {14'd0, mem_rd, mem_wr}, 16'd1);
    chk({tag, " wr_addr"}, mem_addr, addr);
    chk({tag, " wr_data"}, {8'd0, mem_wdata}, {8'd0, exp_mem});
    if (poke_in_write) rdig_start = 1'b1;
    else               rdig_start = 1'b0;
    tick();
    // cycle 4: DONE
    rdig_start = 1'b0;
    chk({tag, " done"}, {15'd0, done}, 16'd1);
    chk({tag, " a_out"}, {8'd0, a_out}, {8'd0, exp_a});
    chk({tag, " flags"}, {12'd0, flag_out}, {12'd0, exp_f});
    chk({tag, " dn_busy"}, {15'd0, busy}, 16'd1);
    chk({tag, " dn_bus"}, {6'd0, mem_rd, mem_wr, mem_wdata}, 16'd0);
    tick();
    // cycle 5: back in IDLE, results held
    chk({tag, " idle"}, {14'd0, busy, done}, 16'd0);
    chk({tag, " a_hold"}, {8'd0, a_out}, {8'd0, exp_a});
    if (poke_in_write) begin
      tick();
      chk({tag, " no_queue"}, {14'd0, busy, mem_rd}, 16'd0);
    end
  endtask

  initial begin
    resetb = 1'b0;
    tick();
    tick();
    chk("rst_ctl", {12'd0, busy, done, mem_rd, mem_wr}, 16'd0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_data", {mem_wdata, a_out}, 16'h0000);
    chk("rst_flags", {12'd0, flag_out}, 16'd0);
    resetb = 1'b1;
    tick();

    // directed cases with known answers
    do_op("rld_12_34", 1'b0, 8'h12, 8'h34, 16'h1234, 1'b1, 1'b0);
    chk("rld_12_34 known", {a_out, 4'd0, flag_out}, 16'h1300);
    do_op("rrd_12_34", 1'b1, 8'h12, 8'h34, 16'hBEEF, 1'b1, 1'b0);
    chk("rrd_12_34 known", {a_out, 4'd0, flag_out}, 16'h1402);
    do_op("rld_00_05", 1'b0, 8'h00, 8'h05, 16'hFFFF, 1'b1, 1'b0);
    chk("rld_00_05 known", {a_out, 4'd0, flag_out}, 16'h0006);

`ifndef RDIG_WAIT_EN
    // acknowledge low has no effect on the fixed-latency build
    do_op("noack", 1'b1, 8'hA7, 8'h9C, 16'h0001, 1'b0, 1'b0);
`else
    // wait states: ack low 3 cycles in READ, 2 in WRITE, DONE in cycle 9
    rdig_start = 1'b1; rdig_op = 1'b0; a_in = 8'h12; addr_in = 16'h4321; mem_ack = 1'b0;
    tick();
    rdig_start = 1'b0; mem_rdata = 8'h34;
    for (int i = 1; i <= 3; i++) begin
      chk("wait_rd", {mem_rd, mem_wr, mem_addr[13:0]}, {2'b10, 14'h0321});
      tick();
    end
    mem_ack = 1'b1;
    chk("wait_rd_last", {15'd0, mem_rd}, 16'd1);
    tick();
    mem_ack = 1'b0;
    tick();
    for (int i = 6; i <= 7; i++) begin
      chk("wait_wr", {mem_rd, mem_wr, 6'd0, mem_wdata}, {2'b01, 6'd0, 8'h42});
      tick();
    end
    mem_ack = 1'b1;
    chk("wait_wr_last", {15'd0, mem_wr}, 16'd1);
    tick();
    chk("wait_done9", {done, 7'd0, a_out}, {1'b1, 7'd0, 8'h13});
    tick();
`endif

    // randomized operations against the model, some with a start pulse in WRITE
    for (int i = 0; i < 10; i++) begin
      do_op("rand", 1'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 1'b1, 1'($urandom));
    end

    // reset during READ: immediate abort, no write afterwards
    rdig_start = 1'b1; rdig_op = 1'b0; a_in = 8'h5A; addr_in = 16'h2222; mem_ack = 1'b1;
    tick();
    rdig_start = 1'b0;
    chk("abort_in_read", {15'd0, mem_rd}, 16'd1);
    resetb = 1'b0;
    tick();
    chk("abort_ctl", {12'd0, busy, done, mem_rd, mem_wr}, 16'd0);
    chk("abort_out", {a_out, 4'd0, flag_out}, 16'h0000);
    chk("abort_bus", mem_addr | {8'd0, mem_wdata}, 16'h0000);
    resetb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_wr", {14'd0, mem_wr, busy}, 16'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_rdig.md
ALU_RDIG -- requirements
Module: alu_rdig

Interface
REQ-001 SHALL have port clkc, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetb, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port rdig_start, input, 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have port rdig_op, input, 1, operation select: 0 = RLD, 1 = RRD; latched with start.
REQ-005 SHALL have port addr_in, input, 16, memory address (HL); latched with start.
REQ-006 SHALL have port a_in, input, 8, accumulator value; latched with start.
REQ-007 SHALL have port mem_rdata, input, 8, memory read data.
REQ-008 SHALL have port mem_ack, input, 1, memory access complete (wait-state release).
REQ-009 SHALL have port mem_rd, output, 1, memory read strobe.
REQ-010 SHALL have port mem_wr, output, 1, memory write strobe.
REQ-011 SHALL have port mem_addr, output, 16, memory address.
REQ-012 SHALL have port mem_wdata, output, 8, memory write data.
REQ-013 SHALL have port a_out, output, 8, result accumulator; held until next start.
REQ-014 SHALL have port flag_out, output, 4, {S, Z, P, H}; N forced 0 and C untouched, neither driven here.
REQ-015 SHALL have ports busy and done, output, 1 each: busy high outside IDLE; done is a one-cycle pulse.

Function
REQ-016 SHALL implement FSM states IDLE, READ, EXEC, WRITE, DONE.
REQ-017 Transitions SHALL be:
- IDLE -> READ when rdig_start=1.
- READ -> EXEC on mem_ack=1.
- EXEC -> WRITE unconditionally.
- WRITE -> DONE on mem_ack=1.
- DONE -> IDLE unconditionally.
REQ-018 mem_rd SHALL be 1 only in READ; mem_wr SHALL be 1 only in WRITE; never both.
REQ-019 mem_addr SHALL equal the latched address in READ and WRITE, and 16'h0000 otherwise.
REQ-020 mem_rdata SHALL be captured on the READ cycle in which mem_ack=1.
REQ-021 RLD: new_mem = {mem[3:0], a[3:0]}; new_a = {a[7:4], mem[7:4]}.
REQ-022 RRD: new_mem = {a[3:0], mem[7:4]}; new_a = {a[7:4], mem[3:0]}.
REQ-023 Both results SHALL be registered in EXEC; mem_wdata SHALL be new_mem in WRITE and 8'h00 otherwise.
REQ-024 Flags SHALL be computed from new_a: S = bit7; Z = (new_a == 0); P = even parity (1 when the count of ones is even); H = 0.
REQ-025 a_out and flag_out SHALL update in the cycle entering DONE; done=1 for exactly that one DONE cycle.
REQ-026 rdig_start while busy SHALL be ignored, with no queuing.
REQ-027 Zero-wait latency SHALL be start accepted at cycle 0; READ 1, EXEC 2, WRITE 3, DONE 4; back-to-back start accepted in cycle 5.

Reset
REQ-028 resetb=0 SHALL force IDLE, with busy, done, mem_rd and mem_wr = 0, mem_addr = 0, mem_wdata = 0, a_out = 0 and flag_out = 0.
REQ-029 Reset mid-operation SHALL abort immediately, with no write issued after the reset cycle.

Configuration
REQ-030 Macro RDIG_WAIT_EN:
- When defined, READ and WRITE SHALL hold until mem_ack=1 (unbounded wait states).
- When undefined, mem_ack SHALL be ignored and each of READ and WRITE SHALL last exactly one cycle.

Structure
REQ-031 The shared definitions file SHALL hold the state encodings (RDIG_IDLE..RDIG_DONE) and the op encodings (RDIG_RLD = 0, RDIG_RRD = 1).
REQ-032 A combinational sub-module rdig_calc SHALL compute new_mem, new_a and the flags from op, a and mem; alu_rdig SHALL hold only the FSM and registers.

Verification
REQ-033 RLD with a_in=8'h12 and mem=8'h34, zero-wait: mem_wdata=8'h42, a_out=8'h13, flag_out S0 Z0 P0 H0; done in cycle 4.
REQ-034 RRD with a_in=8'h12 and mem=8'h34: mem_wdata=8'h23, a_out=8'h14, P=1.
REQ-035 RLD with a_in=8'h00 and mem=8'h05: mem_wdata=8'h50, a_out=8'h00, Z=1, P=1.
REQ-036 With RDIG_WAIT_EN and mem_ack held low 3 cycles in READ and 2 cycles in WRITE: done in cycle 9; strobes held stable throughout.
REQ-037 Start pulsed during WRITE is ignored; resetb=0 during READ gives IDLE the next cycle, with mem_wr never asserted.
